sevseg_scan_driver: RTL and testbench

SEVSEG_SCAN_DRIVER -- requirements
Module: sevseg_scan_driver

---
 rtl/sevseg_pkg.sv | 14 +
 rtl/hex_seg_decode.sv | 12 +
 rtl/sevseg_scan_driver.sv | 124 ++++++++++++
 tb/tb_sevseg_scan_driver.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sevseg_pkg.sv
// sevseg_pkg: shared constants for the seven-segment scan driver.
// Segment bit order is {a,b,c,d,e,f,g}, active-high.
package sevseg_pkg;

    localparam int SEG_W = 7;

    localparam logic [SEG_W-1:0] SEG_TABLE [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79,
        7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F,
        7'h4E, 7'h3D, 7'h4F, 7'h47
    };

endpackage

// File: rtl/hex_seg_decode.sv
// hex_seg_decode: combinational hex nibble to segment pattern.
// Pure table lookup, no state.
module hex_seg_decode
    import sevseg_pkg::*;
(
    input  logic [3:0]       nib,
    output logic [SEG_W-1:0] seg
);

    assign seg = SEG_TABLE[nib];

endmodule

// File: rtl/sevseg_scan_driver.sv
// sevseg_scan_driver: multiplexed seven-segment display scanner.
// Define SEVSEG_BLANK_EN to blank leading zero digits.
module sevseg_scan_driver
    import sevseg_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int PRESCALE = 50000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] value,
    input  logic [N_DIGITS-1:0]   dp_in,
    output logic [SEG_W-1:0]      seg,
    output logic                  dp,
    output logic [N_DIGITS-1:0]   an,
    output logic                  frame_done
);

    localparam int VW = 4 * N_DIGITS;
    localparam int CW = $clog2(PRESCALE);
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(PRESCALE - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(N_DIGITS - 1);

    logic [CW-1:0]       cnt;
    logic [IW-1:0]       idx;
    logic [VW-1:0]       act_val;
    logic [VW-1:0]       pend_val;
    logic [N_DIGITS-1:0] act_dp;
    logic [N_DIGITS-1:0] pend_dp;
    logic                pend;
    logic                tick;
    logic                wrap;
    logic [3:0]          nib;
    logic [SEG_W-1:0]    dec_seg;
    logic                blank;
    logic [N_DIGITS-1:0] sel;

    assign tick = en && (cnt == CNT_MAX);
    assign wrap = tick && (idx == IDX_MAX);
    assign nib  = act_val[{idx, 2'b00} +: 4];

    hex_seg_decode u_dec (
        .nib (nib),
        .seg (dec_seg)
    );

`ifdef SEVSEG_BLANK_EN
    logic [VW-1:0] upper;
    assign upper = act_val >> {idx, 2'b00};
    assign blank = (idx != '0) && (upper == '0);
`else
    assign blank = 1'b0;
`endif

    // One-hot select of the digit currently being scanned.
    always_comb begin
        sel      = '0;
        sel[idx] = 1'b1;
    end

    // Prescaler and digit index; idle holds both at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (!en) begin
            cnt <= '0;
            idx <= '0;
        end else if (tick) begin
            cnt <= '0;
            idx <= wrap ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Double buffer: loads wait in pending until a frame boundary or idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_val  <= '0;
            act_dp   <= '0;
            pend_val <= '0;
            pend_dp  <= '0;
            pend     <= 1'b0;
        end else if (!en || wrap) begin
            if (load) begin
                act_val <= value;
                act_dp  <= dp_in;
            end else if (pend) begin
                act_val <= pend_val;
                act_dp  <= pend_dp;
            end
            pend <= 1'b0;
        end else if (load) begin
            pend_val <= value;
            pend_dp  <= dp_in;
            pend     <= 1'b1;
        end
    end

    // Registered display outputs, one cycle behind idx.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg        <= '0;
            dp         <= 1'b0;
            an         <= '1;
            frame_done <= 1'b0;
        end else if (!en) begin
            seg        <= '0;
            dp         <= 1'b0;
            an         <= '1;
            frame_done <= 1'b0;
        end else begin
            seg        <= blank ? '0 : dec_seg;
            dp         <= act_dp[idx];
            an         <= ~sel;
            frame_done <= wrap;
        end
    end

endmodule

// File: tb/tb_sevseg_scan_driver.sv
// tb_sevseg_scan_driver: scoreboard bench for the scan driver.
// Build with SEVSEG_BLANK_EN to exercise leading-zero blanking.
module tb_sevseg_scan_driver;

    localparam int N = 4;
    localparam int P = 4;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b0;
    logic           en    = 1'b0;
    logic           load  = 1'b0;
    logic [4*N-1:0] value = '0;
    logic [N-1:0]   dp_in = '0;
    logic [6:0]     seg;
    logic           dp;
    logic [N-1:0]   an;
    logic           frame_done;

    int n_total = 0;
    int n_bad   = 0;

    typedef struct packed {
        logic [6:0]   seg;
        logic         dp;
        logic [N-1:0] an;
        logic         fd;
    } exp_t;

    exp_t exp_q[$];
    exp_t mx;

    logic [6:0] segtab [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    // Reference model: what is on screen and what is waiting.
    int             m_slot;
    int             m_digit;
    logic [4*N-1:0] m_val;
    logic [N-1:0]   m_dpv;
    logic [4*N-1:0] p_val;
    logic [N-1:0]   p_dpv;
    bit             m_pend;

    sevseg_scan_driver #(
        .N_DIGITS (N),
        .PRESCALE (P)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .load       (load),
        .value      (value),
        .dp_in      (dp_in),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, act, exp);
        end
    endfunction

    function automatic logic [6:0] shown(int d);
        logic [3:0] nb = m_val[4*d +: 4];
`ifdef SEVSEG_BLANK_EN
        bit zero = 1'b1;
        for (int i = d; i < N; i++)
            if (m_val[4*i +: 4] != 4'h0) zero = 1'b0;
        if (d > 0 && zero) return 7'h00;
`endif
        return segtab[nb];
    endfunction

    function automatic exp_t rst_exp();
        exp_t x;
        x.seg = 7'h00;
        x.dp  = 1'b0;
        x.an  = '1;
        x.fd  = 1'b0;
        return x;
    endfunction

    task automatic model_reset();
        m_slot  = 0;
        m_digit = 0;
        m_val   = '0;
        m_dpv   = '0;
        p_val   = '0;
        p_dpv   = '0;
        m_pend  = 1'b0;
    endtask

    task automatic model_step(input bit e, input bit ld,
                              input logic [4*N-1:0] v,
                              input logic [N-1:0] d,
                              output exp_t x);
        bit slot_end;
        bit frame_end;
        x = rst_exp();
        if (!e) begin
            if (ld) begin
                m_val = v;
                m_dpv = d;
            end else if (m_pend) begin
                m_val = p_val;
                m_dpv = p_dpv;
            end
            m_pend  = 1'b0;
            m_slot  = 0;
            m_digit = 0;
        end else begin
            x.an[m_digit] = 1'b0;
            x.seg = shown(m_digit);
            x.dp  = m_dpv[m_digit];
            slot_end  = (m_slot == P - 1);
            frame_end = slot_end && (m_digit == N - 1);
            x.fd = frame_end;
            if (frame_end) begin
                if (ld) begin
                    m_val = v;
                    m_dpv = d;
                end else if (m_pend) begin
                    m_val = p_val;
                    m_dpv = p_dpv;
                end
                m_pend = 1'b0;
            end else if (ld) begin
                p_val  = v;
                p_dpv  = d;
                m_pend = 1'b1;
            end
            if (slot_end) begin
                m_slot  = 0;
                m_digit = (m_digit + 1) % N;
            end else begin
                m_slot++;
            end
        end
    endtask

    task automatic drive(input bit e, input bit ld,
                         input logic [4*N-1:0] v,
                         input logic [N-1:0] d);
        exp_t x;
        en    = e;
        load  = ld;
        value = v;
        dp_in = d;
        @(posedge clk);
        #1;
        model_step(e, ld, v, d, x);
        exp_q.push_back(x);
        load = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b1, 1'b0, 16'($urandom), 4'($urandom));
    endtask

    task automatic do_reset(input int k);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        load  = 1'b0;
        model_reset();
        #1;
        chk("async_rst_an", 32'(an), 32'hF);
        chk("async_rst_seg", 32'(seg), 32'h0);
        chk("async_rst_fd", 32'(frame_done), 32'h0);
        repeat (k) begin
            @(posedge clk);
            #1;
            exp_q.push_back(rst_exp());
        end
        rst_n = 1'b1;
    endtask

    // Monitor: every falling edge retires one expected output set.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mx = exp_q.pop_front();
            chk("seg", 32'(seg), 32'(mx.seg));
            chk("dp", 32'(dp), 32'(mx.dp));
            chk("an", 32'(an), 32'(mx.an));
            chk("frame_done", 32'(frame_done), 32'(mx.fd));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (3) begin
            @(posedge clk);
            #1;
            exp_q.push_back(rst_exp());
        end
        rst_n = 1'b1;

        drive(1'b1, 1'b0, '0, '0);
        @(negedge clk);
        #1;
        chk("first_slot_an", 32'(an), 32'hE);
        chk("first_slot_seg", 32'(seg), 32'h7E);

        drive(1'b1, 1'b1, 16'h12AF, 4'b0000);
        idle(36);

        for (int i = 0; i < 64 && !(m_digit == 1 && m_slot == 1); i++) idle(1);
        drive(1'b1, 1'b1, 16'h1111, 4'b0000);
        idle(40);

        for (int i = 0; i < 64 && !(m_digit == N-1 && m_slot == P-1); i++) idle(1);
        drive(1'b1, 1'b1, 16'h0008, 4'b0000);
        idle(20);

        drive(1'b1, 1'b1, 16'h0005, 4'b0100);
        idle(40);

        for (int i = 0; i < 64 && m_slot != 2; i++) idle(1);
        drive(1'b0, 1'b0, '0, '0);
        drive(1'b0, 1'b1, 16'hABCD, 4'b1010);
        drive(1'b0, 1'b0, '0, '0);
        idle(12);

        for (int i = 0; i < 64 && !(m_digit == 1 && m_slot == 0); i++) idle(1);
        drive(1'b1, 1'b1, 16'h7777, 4'b1111);
        idle(2);
        do_reset(2);
        idle(8);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0)
                do_reset(1 + int'($urandom_range(0, 2)));
            else
                drive($urandom_range(0, 15) != 0,
                      $urandom_range(0, 9) == 0,
                      16'($urandom), 4'($urandom));
        end

        @(negedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
